// File: rtl/mem_vec_add_seq.sv
// mem_vec_add_seq
// ---------------
// Sequencer that drives the 32-word dual-read-port data memory to compute
// D[k] = A[k] + B[k] for k = 0..len-1. Each element takes two cycles. In the
// first cycle both operands are read over the two read ports. In the second
// cycle the sum is written back over port 1, which shares its address with
// the write port.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle request, only honoured in IDLE
//   base_a/b/d, len   vector bases (5-bit, wrapping) and element count 0..32,
//                     latched when start is accepted
//   mem_addr          port-1 address (read and write)
//   mem_addr2         port-2 read address
//   mem_write_data    write data
//   mem_read          memory read enable
//   mem_write         memory write enable
//   mem_read_data     port-1 read data (combinational from memory)
//   mem_read_data2    port-2 read data (combinational from memory)
//   busy              high while in READ or WRITE
//   done              one-cycle completion pulse
//   carry             sticky carry-out of any element sum
//   count             elements written so far
//
// Every output is registered. This matters for the memory: its write path is
// level-sensitive, so address, data and write enable may change only at clock
// edges.
module mem_vec_add_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   base_a,
  input  logic [4:0]   base_b,
  input  logic [4:0]   base_d,
  input  logic [5:0]   len,
  output logic [4:0]   mem_addr,
  output logic [4:0]   mem_addr2,
  output logic [N-1:0] mem_write_data,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [N-1:0] mem_read_data,
  input  logic [N-1:0] mem_read_data2,
  output logic         busy,
  output logic         done,
  output logic         carry,
  output logic [5:0]   count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   k_q, k_d;
  logic [5:0]   k_inc;
  logic [4:0]   base_a_q, base_a_d;
  logic [4:0]   base_b_q, base_b_d;
  logic [4:0]   base_d_q, base_d_d;
  logic [5:0]   len_q, len_d;
  logic [4:0]   mem_addr_q, mem_addr_d;
  logic [4:0]   mem_addr2_q, mem_addr2_d;
  logic [N-1:0] mem_write_data_q, mem_write_data_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         carry_q, carry_d;
  logic [5:0]   count_q, count_d;
  logic [N:0]   sum_w;

  // Full-width add; bit N is the carry-out of the N-bit word sum.
  function automatic logic [N:0] add_with_carry(input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sum_w = add_with_carry(mem_read_data, mem_read_data2);
  assign k_inc = k_q + 6'd1;

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    base_a_d         = base_a_q;
    base_b_d         = base_b_q;
    base_d_d         = base_d_q;
    len_d            = len_q;
    mem_addr_d       = mem_addr_q;
    mem_addr2_d      = mem_addr2_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    carry_d          = carry_q;
    count_d          = count_q;

    // Outputs are registered, so each branch loads the values for the state
    // being entered, not the state being left.
    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          base_d_d = base_d;
          len_d    = len;
          k_d      = 6'd0;
          count_d  = 6'd0;
          carry_d  = 1'b0;
          if (len != 6'd0) begin
            state_d     = READ;
            mem_addr_d  = base_a;
            mem_addr2_d = base_b;
            mem_read_d  = 1'b1;
            busy_d      = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        mem_write_data_d = sum_w[N-1:0];
        carry_d          = carry_q | sum_w[N];
        mem_addr_d       = base_d_q + k_q[4:0];
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b1;
        state_d          = WRITE;
      end
      WRITE: begin
        k_d         = k_inc;
        count_d     = count_q + 6'd1;
        mem_write_d = 1'b0;
        if (k_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d     = READ;
          mem_addr_d  = base_a_q + k_inc[4:0];
          mem_addr2_d = base_b_q + k_inc[4:0];
          mem_read_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      base_a_q         <= '0;
      base_b_q         <= '0;
      base_d_q         <= '0;
      len_q            <= '0;
      mem_addr_q       <= '0;
      mem_addr2_q      <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      carry_q          <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      base_a_q         <= base_a_d;
      base_b_q         <= base_b_d;
      base_d_q         <= base_d_d;
      len_q            <= len_d;
      mem_addr_q       <= mem_addr_d;
      mem_addr2_q      <= mem_addr2_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      carry_q          <= carry_d;
      count_q          <= count_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_addr2      = mem_addr2_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign carry          = carry_q;
  assign count          = count_q;

endmodule

// File: tb/tb_mem_vec_add_seq.sv
// Testbench for mem_vec_add_seq: a behavioural 32-word dual-read memory
// around the sequencer, with expected writes queued from a reference model.
module tb_mem_vec_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_a, base_b, base_d;
  logic [5:0]  len;
  logic [4:0]  mem_addr, mem_addr2;
  logic [31:0] mem_write_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_read_data, mem_read_data2;
  logic        busy, done, carry;
  logic [5:0]  count;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  logic [4:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  int errors = 0;
  int checks = 0;

  mem_vec_add_seq #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b), .base_d(base_d), .len(len),
    .mem_addr(mem_addr), .mem_addr2(mem_addr2),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .mem_read_data2(mem_read_data2),
    .busy(busy), .done(done), .carry(carry), .count(count)
  );

  always #5 clk = ~clk;

  assign mem_read_data  = mem[mem_addr];
  assign mem_read_data2 = mem[mem_addr2];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_addr] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and score any write seen in that cycle.
  task automatic tick();
    @(negedge clk);
    if (mem_write === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'h1_0000);
      end else begin
        check("wr_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
        check("wr_data", 64'(mem_write_data), 64'(exp_data_q.pop_front()));
      end
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    pre_addr   = a;
    pre_data   = d;
    pre_we     = 1'b1;
    ref_mem[a] = d;
    tick();
    pre_we     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  64'(mem_addr), 0);
    check({tag, "_addr2"}, 64'(mem_addr2), 0);
    check({tag, "_wdata"}, 64'(mem_write_data), 0);
    check({tag, "_rd"},    64'(mem_read), 0);
    check({tag, "_wr"},    64'(mem_write), 0);
    check({tag, "_busy"},  64'(busy), 0);
    check({tag, "_done"},  64'(done), 0);
    check({tag, "_carry"}, 64'(carry), 0);
    check({tag, "_count"}, 64'(count), 0);
  endtask

  // Model the in-order element loop over ref_mem, queueing the first nexp writes.
  task automatic model(input logic [4:0] ba, input logic [4:0] bb, input logic [4:0] bd,
                       input int ln, input int nexp, output logic c);
    logic [32:0] s;
    logic [4:0]  ia, ib, id;
    c = 1'b0;
    for (int k = 0; k < nexp; k++) begin
      ia = ba + 5'(k);
      ib = bb + 5'(k);
      id = bd + 5'(k);
      s  = {1'b0, ref_mem[ia]} + {1'b0, ref_mem[ib]};
      ref_mem[id] = s[31:0];
      exp_addr_q.push_back(id);
      exp_data_q.push_back(s[31:0]);
      c = c | s[32];
    end
    if (nexp != ln) c = 1'b0;
  endtask

  task automatic run(input logic [4:0] ba, input logic [4:0] bb, input logic [4:0] bd,
                     input int ln, input bit inject);
    logic c;
    int   ndone, dcyc, access;
    model(ba, bb, bd, ln, ln, c);
    ndone = 0; dcyc = -1; access = 0;
    base_a = ba; base_b = bb; base_d = bd; len = 6'(ln);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Inputs change after acceptance and must be ignored.
    base_a = ~ba; base_b = ~bb; base_d = ~bd; len = 6'd5;
    for (int cyc = 1; cyc <= 2 * ln + 3; cyc++) begin
      if (cyc > 1) tick();
      check("busy", 64'(busy), 64'((ln > 0) && (cyc <= 2 * ln)));
      if (mem_read && mem_write) check("rd_wr_excl", 1, 0);
      if (done) begin ndone++; dcyc = cyc; end
      if (mem_read || mem_write) access++;
      if (cyc == 1 && ln > 0) begin
        check("rd_addr1", 64'(mem_addr), 64'(ba));
        check("rd_addr2", 64'(mem_addr2), 64'(bb));
        check("rd_en", 64'(mem_read), 1);
        check("carry_cleared", 64'(carry), 0);
      end
      start = (inject && ln > 0 && (cyc == 2 || cyc == 2 * ln + 1)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_pulses", 64'(ndone), 1);
    check("done_cycle", 64'(dcyc), 64'(1 + 2 * ln));
    check("count", 64'(count), 64'(ln));
    check("carry_hold", 64'(carry), 64'(c));
    check("writes_left", 64'(exp_addr_q.size()), 0);
    if (ln == 0) check("len0_access", 64'(access), 0);
  endtask

  initial begin
    logic c;
    rst = 1'b1; start = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    base_a = '0; base_b = '0; base_d = '0; len = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) poke(5'(i), $urandom);

    // Basic two-element add.
    poke(0, 1); poke(1, 2); poke(2, 3); poke(3, 4);
    run(0, 2, 8, 2, 0);
    check("mem8", 64'(mem[8]), 4);
    check("mem9", 64'(mem[9]), 6);

    // Address wrap with D aliased onto A.
    poke(30, 60); poke(0, 1); poke(1, 2);
    run(30, 0, 31, 2, 0);
    check("mem31", 64'(mem[31]), 61);
    check("mem0", 64'(mem[0]), 63);

    // Carry-out, then a run with no carry that must clear it.
    poke(4, 32'hFFFF_FFFF); poke(5, 32'h0000_0001);
    run(4, 5, 6, 1, 0);
    check("mem6", 64'(mem[6]), 0);
    check("carry_set", 64'(carry), 1);
    poke(10, 7); poke(11, 8);
    run(10, 11, 12, 1, 0);
    check("mem12", 64'(mem[12]), 15);

    // Zero-length request.
    run(3, 4, 5, 0, 0);

    // Start pulses while busy and while in DONE are ignored.
    run(16, 20, 24, 3, 1);

    // Full-length run with D aliased onto A.
    run(5, 20, 5, 32, 0);

    // Reset during the second WRITE cycle of a four-element run.
    model(8, 12, 20, 4, 2, c);
    base_a = 8; base_b = 12; base_d = 20; len = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 2; cyc <= 4; cyc++) tick();
    check("rst_mid_wr", 64'(mem_write), 1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("rst_writes_left", 64'(exp_addr_q.size()), 0);
    check("rst_busy", 64'(busy), 0);
    // Memory contents were only partly updated; resync the model.
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    run(1, 2, 3, 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_vec_add_seq.md
Name: mem_vec_add_seq

Overview:
- Sequencer that sits directly upstream of the 32-word dual-read-port data memory and drives all of its ports.
- On start it computes D[k] = A[k] + B[k] for k = 0..len-1.
- Per element it reads both operands in one cycle over the two read ports, then writes the sum in the next cycle over the write port, which shares the port-1 address.
- Serves as the memory-exercising datapath controller for the lab system.

Parameters:
- N, 32, data word width; must match the memory word width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high; same net that clears the memory
- start  input  1  one-cycle request; sampled only in IDLE
- base_a  input  5  base address of operand vector A
- base_b  input  5  base address of operand vector B
- base_d  input  5  base address of destination vector D
- len  input  6  element count, 0..32
- mem_addr  output  5  memory port-1 address (read and write)
- mem_addr2  output  5  memory port-2 read address
- mem_write_data  output  N  write data to memory
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_read_data  input  N  port-1 read data, combinational from memory
- mem_read_data2  input  N  port-2 read data, combinational from memory
- busy  output  1  high in READ and WRITE
- done  output  1  one-cycle completion pulse
- carry  output  1  sticky; set if any element sum carried out of N bits
- count  output  6  number of elements written so far

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, internal index k is 0.
- Reset has priority over everything, including mid-operation. The next edge forces IDLE with mem_write=0, so no partial write is issued after reset.
- At start acceptance, base_a, base_b, base_d and len are latched. Input changes afterwards are ignored until the next start.
- States are IDLE, READ, WRITE and DONE.
- IDLE:
  - start=1 and len!=0 -> READ. Clear k, count and carry.
  - start=1 and len=0 -> DONE. Clear count and carry; no memory access.
  - Otherwise stay in IDLE. mem_read=0, mem_write=0.
- READ:
  - mem_addr = base_a+k, mem_addr2 = base_b+k, mem_read=1, mem_write=0.
  - At the edge, latch sum = mem_read_data + mem_read_data2, keeping the low N bits. OR the carry-out into carry.
  - Next state is WRITE.
- WRITE:
  - mem_addr = base_d+k, mem_write_data = latched sum, mem_write=1, mem_read=0. mem_addr2 holds its value.
  - At the edge, increment k and count.
  - If k+1 == len go to DONE, else go to READ.
- DONE: done=1 for exactly one cycle, then IDLE. count and carry hold until the next start.
- start asserted while busy or in DONE is ignored, not queued.
- Addresses are computed modulo 32 (5-bit wrap), e.g. base 30 with k=3 gives address 1.
- Latency: start seen at edge 0. Element k reads in cycle 1+2k and writes in cycle 2+2k. done is asserted in cycle 1+2·len. With len=0, done is asserted in cycle 1.
- mem_addr, mem_write_data and mem_write change only at clock edges, because the memory write path is level-sensitive.
- Overlapping vectors are defined by strict in-order processing. Element k's write completes before element k+1's read, so D aliased onto A or B reads already-updated values.
- Throughput is one element per 2 cycles.

Test Plan:
- Memory init [0]=1, [1]=2, [2]=3, [3]=4. start with base_a=0, base_b=2, base_d=8, len=2 -> mem[8]=4, mem[9]=6. done asserted exactly in cycle 5, busy in cycles 1–4, count=2, carry=0.
- Wrap and alias: [30]=60, [0]=1, [1]=2. base_a=30, base_b=0, base_d=31, len=2 -> mem[31]=61. Element 1 reads addr 31 (61) and addr 1 (2), so mem[0]=63. mem_addr=0 is asserted in the last WRITE cycle.
- Overflow: preload [4]=0xFFFFFFFF, [5]=0x00000001. base_a=4, base_b=5, base_d=6, len=1 -> mem[6]=0, carry=1. carry stays 1 after done and clears on the next start.
- len=0 -> no mem_read or mem_write ever asserted, done in cycle 1, count=0.
- Reset mid-operation: len=4 run, assert rst during the second WRITE cycle -> next edge has all outputs 0 and state IDLE. No further mem_write. A new start then runs normally.
- start pulses during busy and during DONE -> ignored: exactly one done pulse, count equals the original len.
